// File: rtl/cfs_rx_arb.sv
// Round-robin arbiter with burst lock feeding a single registered RX FIFO push port.
// Optional per-requester grant counters are built when CFS_RX_ARB_STATS_EN is defined.
module cfs_rx_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 37,
    parameter int MAX_BURST  = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                          md_rx_clk,
    input  logic                          preset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          push_valid,
    output logic [DATA_WIDTH-1:0]         push_data,
    input  logic                          push_ready
`ifdef CFS_RX_ARB_STATS_EN
    ,
    input  logic                          clr_stats,
    output logic [NUM_REQ*CNT_WIDTH-1:0]  grant_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int BC_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BC_W-1:0] BC_MAX = BC_W'(MAX_BURST - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    logic                  push_valid_q, push_valid_d;
    logic [DATA_WIDTH-1:0] push_data_q, push_data_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [BC_W-1:0]       burst_cnt_q, burst_cnt_d;
    logic [0:0]            state_q, state_d;

    logic                  load_en;
    logic                  burst_hit;
    logic                  rr_found;
    logic                  grant_vld;
    logic [IDX_W-1:0]      rr_idx;
    logic [IDX_W-1:0]      cand;
    logic [IDX_W-1:0]      grant;
    logic [DATA_WIDTH-1:0] grant_word;
    int                    idx;

    assign push_valid = push_valid_q;
    assign push_data  = push_data_q;

    always_comb begin
        load_en   = !push_valid_q || push_ready;
        burst_hit = req_valid[owner_q] && (burst_cnt_q < BC_MAX);

        // Circular search starting at rr_ptr; first hit wins.
        rr_found = 1'b0;
        rr_idx   = '0;
        idx      = 0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = IDX_W'(idx);
            if (!rr_found && req_valid[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end

        grant     = burst_hit ? owner_q : rr_idx;
        grant_vld = load_en && (burst_hit || rr_found);

        req_ready = '0;
        if (grant_vld) req_ready[grant] = 1'b1;

        grant_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == IDX_W'(i)) grant_word = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        push_valid_d = push_valid_q;
        push_data_d  = push_data_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        burst_cnt_d  = burst_cnt_q;
        state_d      = state_q;
        if (load_en) begin
            if (grant_vld) begin
                push_valid_d = 1'b1;
                push_data_d  = grant_word;
                state_d      = BURST;
                // Coming out of IDLE always starts a fresh burst, even for the old owner.
                if (state_q == IDLE || grant != owner_q) begin
                    owner_d     = grant;
                    burst_cnt_d = '0;
                    rr_ptr_d    = (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                end else if (burst_cnt_q != BC_MAX) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end else begin
                push_valid_d = 1'b0;
                state_d      = IDLE;
            end
        end
    end

    always_ff @(posedge md_rx_clk or negedge preset_n) begin
        if (!preset_n) begin
            push_valid_q <= 1'b0;
            push_data_q  <= '0;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            burst_cnt_q  <= '0;
            state_q      <= IDLE;
        end else begin
            push_valid_q <= push_valid_d;
            push_data_q  <= push_data_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            burst_cnt_q  <= burst_cnt_d;
            state_q      <= state_d;
        end
    end

`ifdef CFS_RX_ARB_STATS_EN
    logic [NUM_REQ-1:0][CNT_WIDTH-1:0] grant_cnt_q, grant_cnt_d;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt_d[i] = grant_cnt_q[i];
            if (clr_stats)
                grant_cnt_d[i] = '0;
            else if (req_ready[i] && req_valid[i] && grant_cnt_q[i] != '1)
                grant_cnt_d[i] = grant_cnt_q[i] + 1'b1;
        end
    end

    always_ff @(posedge md_rx_clk or negedge preset_n) begin
        if (!preset_n) grant_cnt_q <= '0;
        else           grant_cnt_q <= grant_cnt_d;
    end

    assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_cfs_rx_arb.sv
// Directed bench for cfs_rx_arb: one pure round-robin instance and one burst-lock instance,
// with a queue of expected push words checked as the DUT emits them.
module tb_cfs_rx_arb;
    localparam int NR = 4;
    localparam int DW = 37;
    localparam int CW = 2;

    logic             md_rx_clk = 1'b0;
    logic             preset_n;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic             push_ready;
    logic [NR-1:0]    rr_ready, bu_ready;
    logic             rr_pv, bu_pv;
    logic [DW-1:0]    rr_pd, bu_pd;
`ifdef CFS_RX_ARB_STATS_EN
    logic             clr_stats;
    logic [NR*CW-1:0] rr_cnt, bu_cnt;
`endif

    int            vec  = 0;
    int            errs = 0;
    int            cyc  = 0;
    bit            sel;
    bit            exp_pv;
    logic [DW-1:0] sb[$];

    int seq1[5] = '{0, 1, 2, 3, 0};
    int seq2[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

    always #5 md_rx_clk = ~md_rx_clk;

    cfs_rx_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(1), .CNT_WIDTH(CW)) u_rr (
        .md_rx_clk (md_rx_clk),
        .preset_n  (preset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (rr_ready),
        .push_valid(rr_pv),
        .push_data (rr_pd),
        .push_ready(push_ready)
`ifdef CFS_RX_ARB_STATS_EN
        ,
        .clr_stats (clr_stats),
        .grant_cnt (rr_cnt)
`endif
    );

    cfs_rx_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(4), .CNT_WIDTH(CW)) u_bu (
        .md_rx_clk (md_rx_clk),
        .preset_n  (preset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (bu_ready),
        .push_valid(bu_pv),
        .push_data (bu_pd),
        .push_ready(push_ready)
`ifdef CFS_RX_ARB_STATS_EN
        ,
        .clr_stats (clr_stats),
        .grant_cnt (bu_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Word i carries its requester index and the cycle it was presented.
    task automatic drive_data();
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = {5'(i), 32'(cyc)};
    endtask

    // One clock: check at negedge against expected grant g (-1 = none), then advance.
    task automatic tick(input int g);
        logic [NR-1:0] o_rdy;
        logic          o_pv;
        logic [DW-1:0] o_pd;
        logic [DW-1:0] head;
        logic [63:0]   e_rdy;
        @(negedge md_rx_clk);
        o_rdy = sel ? bu_ready : rr_ready;
        o_pv  = sel ? bu_pv : rr_pv;
        o_pd  = sel ? bu_pd : rr_pd;
        e_rdy = (g < 0) ? 64'd0 : (64'd1 << g);
        chk("push_valid", 64'(o_pv), 64'(exp_pv));
        chk("req_ready", 64'(o_rdy), e_rdy);
        if (o_pv && push_ready) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                head = sb.pop_front();
                chk("push_data", 64'(o_pd), 64'(head));
            end
        end else if (o_pv && sb.size() != 0) begin
            chk("push_data_hold", 64'(o_pd), 64'(sb[0]));
        end
        if (g >= 0) sb.push_back({5'(g), 32'(cyc)});
        if (!exp_pv || push_ready) exp_pv = (g >= 0);
        @(posedge md_rx_clk);
        #1;
        cyc++;
        drive_data();
    endtask

    task automatic do_reset();
        preset_n = 1'b0;
        #2;
        chk("rst_async_pv", 64'(sel ? bu_pv : rr_pv), 64'd0);
        sb.delete();
        exp_pv = 1'b0;
        @(posedge md_rx_clk);
        #1;
        preset_n = 1'b1;
    endtask

    initial begin
        preset_n   = 1'b0;
        req_valid  = '0;
        push_ready = 1'b1;
        sel        = 1'b0;
        exp_pv     = 1'b0;
`ifdef CFS_RX_ARB_STATS_EN
        clr_stats  = 1'b0;
`endif
        drive_data();

        @(negedge md_rx_clk);
        chk("rst_rr_pv", 64'(rr_pv), 64'd0);
        chk("rst_bu_pv", 64'(bu_pv), 64'd0);
        chk("rst_rr_ready", 64'(rr_ready), 64'd0);
        chk("rst_bu_ready", 64'(bu_ready), 64'd0);
        chk("rst_bu_pd", 64'(bu_pd), 64'd0);
`ifdef CFS_RX_ARB_STATS_EN
        chk("rst_grant_cnt", 64'(bu_cnt), 64'd0);
`endif
        @(posedge md_rx_clk);
        #1;
        preset_n = 1'b1;

        // Pure round-robin, then reset with a word in flight and restart at 0.
        req_valid = 4'b1111;
        foreach (seq1[i]) tick(seq1[i]);
        do_reset();
        tick(0);
        req_valid = '0;
        tick(-1);
        tick(-1);

        // Burst lock between two requesters.
        sel = 1'b1;
        do_reset();
        req_valid = 4'b0011;
        foreach (seq2[i]) tick(seq2[i]);
        req_valid = '0;
        tick(-1);
        tick(-1);

        // Lone requester keeps winning past the burst limit; then a 5-cycle stall.
        req_valid = 4'b0100;
        repeat (10) tick(2);
        push_ready = 1'b0;
        repeat (5) tick(-1);
        push_ready = 1'b1;
        tick(2);
        req_valid = '0;
        tick(-1);
        tick(-1);

        // Owner drops valid mid-burst: next requester granted with no bubble.
        do_reset();
        req_valid = 4'b0011;
        tick(0);
        tick(0);
        req_valid = 4'b0010;
        tick(1);
        req_valid = '0;
        tick(-1);
        tick(-1);

`ifdef CFS_RX_ARB_STATS_EN
        do_reset();
        req_valid = 4'b0010;
        repeat (5) tick(1);
        chk("cnt1_sat", 64'(bu_cnt[2*CW-1:CW]), 64'd3);
        chk("cnt0_zero", 64'(bu_cnt[CW-1:0]), 64'd0);
        clr_stats = 1'b1;
        tick(1);
        clr_stats = 1'b0;
        chk("cnt1_clr", 64'(bu_cnt[2*CW-1:CW]), 64'd0);
        tick(1);
        chk("cnt1_after_clr", 64'(bu_cnt[2*CW-1:CW]), 64'd1);
        req_valid = '0;
        tick(-1);
        tick(-1);
`endif

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
